// File: rtl/spi_txn_ctrl_if.sv
// spi_txn_ctrl_if: bundles the command, write stream, read stream, status
// and byte-level SPI master signals of spi_txn_ctrl.
//
// Handshake rules: cmd_valid_i/cmd_ready_o and wr_valid_i/wr_ready_o are
// plain valid/ready pairs. A transfer happens on the rising clock edge where
// both are high. The sender must hold valid and its payload stable until
// that edge. The receiver's ready never depends on the sender's valid.
// rd_valid_o is a one-cycle strobe with no backpressure.
interface spi_txn_ctrl_if;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic       cmd_rw_i;
    logic [6:0] cmd_addr_i;
    logic [7:0] cmd_len_i;
    logic [7:0] wr_data_i;
    logic       wr_valid_i;
    logic       wr_ready_o;
    logic [7:0] rd_data_o;
    logic       rd_valid_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic       spi_en_o;
    logic [7:0] spi_mosi_data_o;
    logic [7:0] spi_miso_data_i;
    logic       spi_data_ready_i;
    logic       spi_cs_i;
    logic [1:0] dbg_state;

    // Sequencer side.
    modport slave (
        input  cmd_valid_i, cmd_rw_i, cmd_addr_i, cmd_len_i,
        input  wr_data_i, wr_valid_i,
        input  spi_miso_data_i, spi_data_ready_i, spi_cs_i,
        output cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o,
        output busy_o, done_o, err_o, spi_en_o, spi_mosi_data_o,
        output dbg_state
    );

    // Environment side: the command issuer plus the byte-level SPI master.
    modport master (
        output cmd_valid_i, cmd_rw_i, cmd_addr_i, cmd_len_i,
        output wr_data_i, wr_valid_i,
        output spi_miso_data_i, spi_data_ready_i, spi_cs_i,
        input  cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o,
        input  busy_o, done_o, err_o, spi_en_o, spi_mosi_data_o,
        input  dbg_state
    );
endinterface

// File: rtl/spi_txn_ctrl.sv
// spi_txn_ctrl: register-access transaction sequencer in front of a
// byte-level SPI master. It sends the header {rw, addr} and then cmd_len
// data bytes, keeping the master enabled so that CS stays low throughout.
// Optional macro SPI_TXN_TIMEOUT_EN adds a watchdog of P_TIMEOUT cycles.
module spi_txn_ctrl #(
    parameter logic [7:0]  P_DUMMY_BYTE = 8'h00,
    parameter int unsigned P_TIMEOUT    = 4096
) (
    input logic           clk_i,
    input logic           rst_i,
    spi_txn_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_XFER    = 2'd1;
    localparam logic [1:0] S_WAIT_CS = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0] state;
    logic       rw_q;
    logic [7:0] len_q;
    logic [8:0] k_q;        // bytes completed in this transaction, header included
    logic [8:0] k_next;
    logic [8:0] len_ext;
    logic [7:0] fetched_q;  // write bytes accepted into the holding register
    logic [7:0] hold_q;
    logic       hold_full;
    logic       err_flag;
    logic       en_q;
    logic [7:0] mosi_q;
    logic [7:0] rd_data_q;
    logic       rd_valid_q;
    logic       wr_ready;
    logic       wr_fire;
`ifdef SPI_TXN_TIMEOUT_EN
    logic [31:0] tmo_cnt;
`endif

    assign k_next   = k_q + 9'd1;
    assign len_ext  = {1'b0, len_q};
    assign wr_ready = (state == S_XFER) && !rw_q && !hold_full && (fetched_q < len_q);
    assign wr_fire  = bus.wr_valid_i && wr_ready;

    assign bus.cmd_ready_o     = (state == S_IDLE);
    assign bus.busy_o          = (state != S_IDLE);
    assign bus.done_o          = (state == S_DONE);
    assign bus.err_o           = (state == S_DONE) && err_flag;
    assign bus.wr_ready_o      = wr_ready;
    assign bus.rd_data_o       = rd_data_q;
    assign bus.rd_valid_o      = rd_valid_q;
    assign bus.spi_en_o        = en_q;
    assign bus.spi_mosi_data_o = mosi_q;
    assign bus.dbg_state       = state;

    // Transaction FSM, write holding register and SPI master drive.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            rw_q       <= 1'b0;
            len_q      <= 8'd0;
            k_q        <= 9'd0;
            fetched_q  <= 8'd0;
            hold_q     <= 8'd0;
            hold_full  <= 1'b0;
            err_flag   <= 1'b0;
            en_q       <= 1'b0;
            mosi_q     <= 8'd0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
`ifdef SPI_TXN_TIMEOUT_EN
            tmo_cnt    <= 32'd0;
`endif
        end else begin
            rd_valid_q <= 1'b0;
            // Prefetch only runs in S_XFER while the register is empty, so it
            // never collides with the register being drained below.
            if (wr_fire) begin
                hold_q    <= bus.wr_data_i;
                hold_full <= 1'b1;
                fetched_q <= fetched_q + 8'd1;
            end
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid_i) begin
                        rw_q      <= bus.cmd_rw_i;
                        len_q     <= bus.cmd_len_i;
                        k_q       <= 9'd0;
                        fetched_q <= 8'd0;
                        hold_full <= 1'b0;
                        en_q      <= 1'b1;
                        mosi_q    <= {bus.cmd_rw_i, bus.cmd_addr_i};
                        state     <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (bus.spi_data_ready_i) begin
                        k_q <= k_next;
                        // The header byte's receive data is never forwarded.
                        if (rw_q && (k_next >= 9'd2)) begin
                            rd_data_q  <= bus.spi_miso_data_i;
                            rd_valid_q <= 1'b1;
                        end
                        if (k_next <= len_ext) begin
                            if (rw_q) begin
                                mosi_q <= P_DUMMY_BYTE;
                            end else if (hold_full) begin
                                mosi_q    <= hold_q;
                                hold_full <= 1'b0;
                            end else begin
                                // Underrun: no write byte ready in time.
                                en_q     <= 1'b0;
                                err_flag <= 1'b1;
                                state    <= S_WAIT_CS;
                            end
                        end else begin
                            en_q  <= 1'b0;
                            state <= S_WAIT_CS;
                        end
                    end
                end
                S_WAIT_CS: begin
                    if (bus.spi_cs_i) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    err_flag  <= 1'b0;
                    hold_full <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
`ifdef SPI_TXN_TIMEOUT_EN
            // Watchdog: restarts on every byte completion and on state entry.
            if (state == S_IDLE) begin
                tmo_cnt <= 32'd0;
            end else if ((state == S_XFER) || (state == S_WAIT_CS)) begin
                if (bus.spi_data_ready_i) begin
                    tmo_cnt <= 32'd0;
                end else if (tmo_cnt == P_TIMEOUT - 1) begin
                    tmo_cnt  <= 32'd0;
                    en_q     <= 1'b0;
                    err_flag <= 1'b1;
                    state    <= S_DONE;
                end else begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_spi_txn_ctrl.sv
// tb_spi_txn_ctrl: directed plus randomized transactions against spi_txn_ctrl,
// with a behavioural byte-level SPI master and write-data feeder.
module tb_spi_txn_ctrl;
  localparam logic [7:0] DUMMY = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  spi_txn_ctrl_if bus();

  spi_txn_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  // ---------------- scoreboard state
  logic [7:0] exp_q[$];       // expected MOSI bytes of the current transaction
  logic [7:0] exp_rd_q[$];    // expected read stream bytes
  logic [7:0] mosi_act_q[$];  // bytes the SPI master shifted out
  logic [7:0] rd_act_q[$];    // bytes seen on the read stream
  int         frame_q[$];     // bytes per CS-low frame
  logic [7:0] slave_q[$];     // bytes the slave returns, one per SPI byte
  logic [7:0] wr_feed_q[$];   // bytes offered on the write stream
  logic [7:0] fixed_wr_q[$];  // directed write data (else random)
  logic [7:0] fixed_sl_q[$];  // directed slave data (else random)
  int         done_cnt = 0;
  int         frame_bytes = 0;
  logic       wr_fire = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural byte-level SPI master
  initial begin
    logic [7:0] sb;
    bus.spi_cs_i = 1'b1;
    bus.spi_data_ready_i = 1'b0;
    bus.spi_miso_data_i = 8'h00;
    forever begin
      @(negedge clk);
      while (bus.spi_en_o === 1'b1) begin
        bus.spi_cs_i = 1'b0;
        mosi_act_q.push_back(bus.spi_mosi_data_o);
        frame_bytes++;
        sb = (slave_q.size() > 0) ? slave_q.pop_front() : 8'hEE;
        repeat ($urandom_range(2, 6)) @(negedge clk);
        bus.spi_miso_data_i = sb;
        bus.spi_data_ready_i = 1'b1;
        @(negedge clk);
        bus.spi_data_ready_i = 1'b0;
      end
      if (!bus.spi_cs_i) begin
        bus.spi_cs_i = 1'b1;
        frame_q.push_back(frame_bytes);
        frame_bytes = 0;
      end
    end
  end

  // ---------------- write stream driver
  initial begin
    bus.wr_valid_i = 1'b0;
    bus.wr_data_i = 8'h00;
    forever begin
      @(negedge clk);
      if (wr_fire && wr_feed_q.size() > 0) void'(wr_feed_q.pop_front());
      if (wr_feed_q.size() > 0) begin
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i = wr_feed_q[0];
      end else begin
        bus.wr_valid_i = 1'b0;
      end
      wr_fire = bus.wr_valid_i && (bus.wr_ready_o === 1'b1) && !rst;
    end
  end

  // ---------------- output monitors
  always @(negedge clk) begin
    if (bus.rd_valid_o === 1'b1) rd_act_q.push_back(bus.rd_data_o);
    if (bus.done_o === 1'b1) done_cnt++;
  end

  // ---------------- driver tasks
  task automatic issue_cmd(input logic rw, input logic [6:0] addr, input int len);
    int cyc;
    @(negedge clk);
    bus.cmd_rw_i = rw;
    bus.cmd_addr_i = addr;
    bus.cmd_len_i = len[7:0];
    bus.cmd_valid_i = 1'b1;
    cyc = 0;
    while (bus.cmd_ready_o !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
  endtask

  // Builds the expected transaction from the command rules, runs it, compares.
  task automatic run_txn(input string tag, input logic rw, input logic [6:0] addr,
                         input int len, input int supply);
    logic [7:0] b;
    int n_wr;
    int cyc;
    int done_before;
    logic exp_err;
    exp_q.delete(); exp_rd_q.delete(); mosi_act_q.delete();
    rd_act_q.delete(); frame_q.delete(); slave_q.delete();
    exp_q.push_back({rw, addr});
    for (int i = 0; i <= len; i++) begin
      b = (fixed_sl_q.size() > 0) ? fixed_sl_q.pop_front() : 8'($urandom_range(0, 255));
      slave_q.push_back(b);
      if (rw && i >= 1) exp_rd_q.push_back(b);
    end
    if (rw) begin
      for (int i = 0; i < len; i++) exp_q.push_back(DUMMY);
      exp_err = 1'b0;
    end else begin
      n_wr = (supply < len) ? supply : len;
      for (int i = 0; i < n_wr; i++) begin
        b = (fixed_wr_q.size() > 0) ? fixed_wr_q.pop_front() : 8'($urandom_range(0, 255));
        wr_feed_q.push_back(b);
        exp_q.push_back(b);
      end
      exp_err = (supply < len);
    end
    done_before = done_cnt;
    issue_cmd(rw, addr, len);
    cyc = 0;
    while (bus.done_o !== 1'b1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ":done"}, 32'(bus.done_o), 32'd1);
    check({tag, ":err"}, 32'(bus.err_o), 32'(exp_err));
    @(negedge clk);
    check({tag, ":cmd_ready_after"}, 32'(bus.cmd_ready_o), 32'd1);
    check({tag, ":busy_after"}, 32'(bus.busy_o), 32'd0);
    repeat (2) @(negedge clk);
    check({tag, ":done_pulses"}, 32'(done_cnt - done_before), 32'd1);
    check({tag, ":frames"}, 32'(frame_q.size()), 32'd1);
    check({tag, ":frame_len"}, 32'((frame_q.size() > 0) ? frame_q[0] : 0), 32'(exp_q.size()));
    check({tag, ":mosi_count"}, 32'(mosi_act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < mosi_act_q.size())
        check($sformatf("%s:mosi[%0d]", tag, i), 32'(mosi_act_q[i]), 32'(exp_q[i]));
    check({tag, ":rd_count"}, 32'(rd_act_q.size()), 32'(exp_rd_q.size()));
    for (int i = 0; i < exp_rd_q.size(); i++)
      if (i < rd_act_q.size())
        check($sformatf("%s:rd[%0d]", tag, i), 32'(rd_act_q[i]), 32'(exp_rd_q[i]));
    wr_feed_q.delete();
  endtask

  // ---------------- directed and random steps
  initial begin
    int cyc;
    int len;
    int supply;
    logic rw;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_rw_i = 1'b0;
    bus.cmd_addr_i = 7'd0;
    bus.cmd_len_i = 8'd0;
    repeat (3) @(negedge clk);
    check("rst:cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    check("rst:busy", 32'(bus.busy_o), 32'd0);
    check("rst:done", 32'(bus.done_o), 32'd0);
    check("rst:err", 32'(bus.err_o), 32'd0);
    check("rst:spi_en", 32'(bus.spi_en_o), 32'd0);
    check("rst:mosi", 32'(bus.spi_mosi_data_o), 32'd0);
    check("rst:rd_valid", 32'(bus.rd_valid_o), 32'd0);
    check("rst:rd_data", 32'(bus.rd_data_o), 32'd0);
    check("rst:wr_ready", 32'(bus.wr_ready_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    fixed_wr_q = '{8'hA5, 8'h3C};
    run_txn("wr2", 1'b0, 7'h15, 2, 2);
    fixed_sl_q = '{8'h5A, 8'h11, 8'h22, 8'h33};
    run_txn("rd3", 1'b1, 7'h7F, 3, 0);
    run_txn("rd0", 1'b1, 7'h2A, 0, 0);
    run_txn("wr0", 1'b0, 7'h01, 0, 0);
    run_txn("underrun", 1'b0, 7'h33, 3, 1);
    run_txn("underrun0", 1'b0, 7'h44, 2, 0);

    // Reset in the middle of a read.
    mosi_act_q.delete(); rd_act_q.delete(); slave_q.delete();
    for (int i = 0; i < 7; i++) slave_q.push_back(8'($urandom_range(0, 255)));
    issue_cmd(1'b1, 7'h0C, 6);
    cyc = 0;
    while (mosi_act_q.size() < 3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("abort:reach_byte3", 32'(mosi_act_q.size() >= 3), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_act_q.delete();
    check("abort:spi_en", 32'(bus.spi_en_o), 32'd0);
    check("abort:busy", 32'(bus.busy_o), 32'd0);
    check("abort:cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    cyc = 0;
    while (bus.spi_cs_i !== 1'b1 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("abort:cs_release", 32'(bus.spi_cs_i), 32'd1);
    repeat (4) @(negedge clk);
    check("abort:no_rd_valid", 32'(rd_act_q.size()), 32'd0);
    check("abort:idle", 32'(bus.busy_o), 32'd0);
    run_txn("after_abort", 1'b1, 7'h05, 2, 0);

    // Randomized transactions, occasionally starving the write stream.
    for (int t = 0; t < 12; t++) begin
      rw = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 10);
      supply = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : len;
      run_txn($sformatf("rand%0d", t), rw, 7'($urandom_range(0, 127)), len, supply);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
